// File: rtl/cpu_mem_arbiter.sv
// Two-port arbiter/sequencer for the CPU_MEM 256x8 SRAM with a lock FSM and
// 2-cycle read return tracking. Define CPU_MEM_ARB_RR_EN for round-robin arbitration.
module cpu_mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic                  p0_lock,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic                  p1_lock,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_csb,
    output logic                  mem_web,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       gnt0, gnt1;
    logic       pref1;
    logic [1:0] rd_q, rd_d;
    logic [1:0] port_q, port_d;

`ifdef CPU_MEM_ARB_RR_EN
    logic rr_q, rr_d;

    always_comb begin
        rr_d = rr_q ^ (gnt0 | gnt1);
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign pref1 = rr_q;
`else
    assign pref1 = 1'b0;
`endif

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE: begin
                if (gnt0 && p0_lock) begin
                    state_d = OWN0;
                end else if (gnt1 && p1_lock) begin
                    state_d = OWN1;
                end
            end
            OWN0: if (gnt0 && !p0_lock) state_d = FREE;
            OWN1: if (gnt1 && !p1_lock) state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    // Grants are forced low while reset is asserted so the SRAM sees no access.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            case (state_q)
                FREE: begin
                    if (p0_valid && (!p1_valid || !pref1)) begin
                        gnt0 = 1'b1;
                    end else if (p1_valid) begin
                        gnt1 = 1'b1;
                    end
                end
                OWN0:    gnt0 = p0_valid;
                OWN1:    gnt1 = p1_valid;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_csb  = 1'b1;
        mem_web  = 1'b1;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt0) begin
            mem_csb  = 1'b0;
            mem_web  = ~p0_we;
            mem_addr = p0_addr;
            mem_din  = p0_wdata;
        end else if (gnt1) begin
            mem_csb  = 1'b0;
            mem_web  = ~p1_we;
            mem_addr = p1_addr;
            mem_din  = p1_wdata;
        end
    end

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    // Stage 0 holds reads issued last cycle; stage 1 lines up with SRAM dout.
    always_comb begin
        rd_d[0]   = (gnt0 & ~p0_we) | (gnt1 & ~p1_we);
        port_d[0] = gnt1;
        rd_d[1]   = rd_q[0];
        port_d[1] = port_q[0];
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            port_q <= '0;
        end else begin
            rd_q   <= rd_d;
            port_q <= port_d;
        end
    end

    assign p0_rvalid = rd_q[1] & ~port_q[1];
    assign p1_rvalid = rd_q[1] & port_q[1];
    assign p0_rdata  = p0_rvalid ? mem_dout : '0;
    assign p1_rdata  = p1_rvalid ? mem_dout : '0;

endmodule
